// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller in front of the combinational alu: owns the 16x8
// register file and the flags register. Optional macro ALU_EXEC_FWD_EN overlaps WB with accept.
module alu_exec_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int OPER_WIDTH     = 4,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int FLAGS_WIDTH    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [OPER_WIDTH-1:0]     instr_oper,
    input  logic [REG_ADDR_WIDTH-1:0] instr_rd,
    input  logic [REG_ADDR_WIDTH-1:0] instr_rs,
    input  logic                      instr_imm_sel,
    input  logic [DATA_WIDTH-1:0]     instr_imm,
    output logic [OPER_WIDTH-1:0]     alu_oper,
    output logic [DATA_WIDTH-1:0]     alu_a,
    output logic [DATA_WIDTH-1:0]     alu_b,
    output logic [FLAGS_WIDTH-1:0]    alu_flags,
    input  logic [DATA_WIDTH-1:0]     alu_result,
    input  logic [FLAGS_WIDTH-1:0]    alu_flags_result,
    output logic                      result_valid,
    output logic [DATA_WIDTH-1:0]     result_data,
    output logic [REG_ADDR_WIDTH-1:0] result_rd,
    output logic                      result_we,
    output logic                      illegal_oper,
    output logic [FLAGS_WIDTH-1:0]    flags,
    input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]     dbg_data
);

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
    localparam logic [OPER_WIDTH-1:0] OP_CMP = OPER_WIDTH'(32'd4);
    localparam logic [OPER_WIDTH-1:0] OP_LSR = OPER_WIDTH'(32'd9);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic                      accept_s;
    logic [DATA_WIDTH-1:0]     a_src_s;
    logic [DATA_WIDTH-1:0]     b_src_s;
    logic [DATA_WIDTH-1:0]     rf_r [NUM_REGS];
    logic [OPER_WIDTH-1:0]     oper_r;
    logic [REG_ADDR_WIDTH-1:0] rd_r;
    logic [DATA_WIDTH-1:0]     a_r;
    logic [DATA_WIDTH-1:0]     b_r;
    logic [FLAGS_WIDTH-1:0]    flags_r;
    logic [FLAGS_WIDTH-1:0]    res_flags_r;
    logic [DATA_WIDTH-1:0]     res_data_r;
    logic [REG_ADDR_WIDTH-1:0] res_rd_r;
    logic                      res_valid_r;
    logic                      res_we_r;
    logic                      res_ill_r;

    function automatic logic oper_legal(input logic [OPER_WIDTH-1:0] op);
        return (op <= OP_LSR);
    endfunction

    function automatic logic oper_writes_rf(input logic [OPER_WIDTH-1:0] op);
        return oper_legal(op) && (op != OP_CMP);
    endfunction

    assign accept_s     = instr_valid && instr_ready;
    assign alu_oper     = oper_r;
    assign alu_a        = a_r;
    assign alu_b        = b_r;
    assign alu_flags    = flags_r;
    assign flags        = flags_r;
    assign result_valid = res_valid_r;
    assign result_data  = res_data_r;
    assign result_rd    = res_rd_r;
    assign result_we    = res_we_r;
    assign illegal_oper = res_ill_r;
    assign dbg_data     = rf_r[dbg_addr];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_EXEC;
                else          state_nxt_s = ST_IDLE;
            end
            ST_EXEC: state_nxt_s = ST_WB;
            ST_WB: begin
                if (accept_s) state_nxt_s = ST_EXEC;
                else          state_nxt_s = ST_IDLE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: acceptance window
    always_comb begin
        instr_ready = 1'b0;
        case (state_r)
            ST_IDLE: instr_ready = 1'b1;
`ifdef ALU_EXEC_FWD_EN
            ST_WB:   instr_ready = 1'b1;
`else
            ST_WB:   instr_ready = 1'b0;
`endif
            default: instr_ready = 1'b0;
        endcase
    end

    // Operand select; with forwarding the committing result bypasses the RF
    always_comb begin
        a_src_s = rf_r[instr_rd];
        if (instr_imm_sel) begin
            b_src_s = instr_imm;
        end else begin
            b_src_s = rf_r[instr_rs];
        end
`ifdef ALU_EXEC_FWD_EN
        if ((state_r == ST_WB) && res_we_r && (res_rd_r == instr_rd)) begin
            a_src_s = res_data_r;
        end else begin
            a_src_s = rf_r[instr_rd];
        end
        if ((state_r == ST_WB) && res_we_r && !instr_imm_sel && (res_rd_r == instr_rs)) begin
            b_src_s = res_data_r;
        end else begin
            b_src_s = b_src_s;
        end
`endif
    end

    // Operand latch and result capture pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            oper_r      <= '0;
            rd_r        <= '0;
            a_r         <= '0;
            b_r         <= '0;
            res_data_r  <= '0;
            res_flags_r <= '0;
            res_rd_r    <= '0;
            res_valid_r <= 1'b0;
            res_we_r    <= 1'b0;
            res_ill_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                oper_r <= instr_oper;
                rd_r   <= instr_rd;
                a_r    <= a_src_s;
                b_r    <= b_src_s;
            end
            if (state_r == ST_EXEC) begin
                res_data_r  <= alu_result;
                res_flags_r <= alu_flags_result;
                res_rd_r    <= rd_r;
                res_valid_r <= 1'b1;
                res_we_r    <= oper_writes_rf(oper_r);
                res_ill_r   <= !oper_legal(oper_r);
            end else begin
                res_valid_r <= 1'b0;
                res_we_r    <= 1'b0;
                res_ill_r   <= 1'b0;
            end
        end
    end

    // Commit: register file write and flags update at the end of WB
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_r[i] <= '0;
            end
            flags_r <= '0;
        end else if (state_r == ST_WB) begin
            if (res_we_r) begin
                rf_r[res_rd_r] <= res_data_r;
            end
            if (!res_ill_r) begin
                flags_r <= res_flags_r;
            end
        end
    end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Execute-stage controller directly upstream of the combinational alu. Owns a 16x8 register file and the processor flags register, and accepts one decoded instruction at a time via valid/ready. It drives the alu's oper/a_in/b_in/proc_flags_in from registered operands, captures the alu's out/proc_flags_out, then commits the result to the register file and the flags.

Parameters:
DATA_WIDTH, 8, alu operand/result width; equals const_alu_inout_width.
OPER_WIDTH, 4, opcode width; equals const_alu_oper_msb_pos+1.
REG_ADDR_WIDTH, 4, register index width (2**REG_ADDR_WIDTH registers).
FLAGS_WIDTH, 2, flags width; bit positions follow enum_proc_flag_c / enum_proc_flag_z.

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  synchronous, active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  controller can accept
instr_oper  in  OPER_WIDTH  alu opcode
instr_rd  in  REG_ADDR_WIDTH  dest / A-operand register
instr_rs  in  REG_ADDR_WIDTH  B-operand register
instr_imm_sel  in  1  1: B = instr_imm, 0: B = RF[instr_rs]
instr_imm  in  DATA_WIDTH  immediate
alu_oper  out  OPER_WIDTH  to alu.oper
alu_a  out  DATA_WIDTH  to alu.a_in
alu_b  out  DATA_WIDTH  to alu.b_in
alu_flags  out  FLAGS_WIDTH  to alu.proc_flags_in (current flags reg)
alu_result  in  DATA_WIDTH  from alu.out
alu_flags_result  in  FLAGS_WIDTH  from alu.proc_flags_out
result_valid  out  1  one-cycle pulse, result committing
result_data  out  DATA_WIDTH  captured result
result_rd  out  REG_ADDR_WIDTH  captured destination
result_we  out  1  RF write happens this commit
illegal_oper  out  1  with result_valid: opcode not implemented
flags  out  FLAGS_WIDTH  committed flags register
dbg_addr  in  REG_ADDR_WIDTH  debug read index
dbg_data  out  DATA_WIDTH  combinational RF[dbg_addr] (committed state)

Behaviour:
- Opcodes: add 0, adc 1, sub 2, sbc 3, cmp 4, and 5, or 6, xor 7, lsl 8, lsr 9; 4'hA-4'hF illegal.
- FSM states IDLE, EXEC, WB. instr_ready = (state==IDLE).
- IDLE: on instr_valid at edge N, latch oper, rd, A=RF[rd], B=(imm_sel ? imm : RF[rs]); go to EXEC.
- EXEC (cycle N..N+1): alu_oper/alu_a/alu_b come from latched registers only (never combinational from instr_*); alu_flags = flags reg. At edge N+1 capture alu_result and alu_flags_result; go to WB.
- WB (cycle N+1..N+2): result_valid=1; result_we=1 for ops 0-3,5-9, 0 for cmp and illegal. At edge N+2: if result_we, RF[rd] <= result_data; flags <= captured flags for legal ops (cmp included), unchanged for illegal; go to IDLE.
- Illegal opcode: illegal_oper=1 during WB; no RF or flags change; captured alu values ignored (alu outputs undefined there).
- Latency: accept edge N -> result_valid during cycle N+1..N+2 -> committed/visible on dbg_data and flags after edge N+2. Throughput: 1 instruction per 3 cycles.
- rd==rs: both operands read the same committed value. No hazards: execution is serialized.
- alu_oper/alu_a/alu_b hold their last values outside EXEC.
- Reset (any state, including mid-EXEC/WB): state=IDLE, all RF entries 0, flags 0, result_valid/result_we/illegal_oper 0, result_data/result_rd 0, alu_oper/alu_a/alu_b 0. In-flight instruction is dropped with no commit. instr_ready=1 in the first cycle after reset.

Optional Feature:
ALU_EXEC_FWD_EN. Defined: instr_ready is also 1 during WB. An instruction accepted at the WB edge reads operands with forwarding: the A/B operand takes result_data when its register equals result_rd and result_we=1. Its alu_flags come from the committing flags. Throughput is 1 per 2 cycles. Undefined: instr_ready only in IDLE, no forwarding logic synthesized.

Test Plan:
- Reset, then RF[1]=0x7F via imm path (or 1, imm 0x7F onto RF[1]=0 -> result 0x7F), then add rd=1, imm 0x01 -> result 0x80, C=0, Z=0, result_valid exactly 2 cycles after accept.
- RF[2]=0xFF; add rd=2, imm 0x01 -> RF[2]=0x00, C=1, Z=1; following adc rd=2, imm 0x00 -> 0x01, C=0.
- RF[3]=0x05; cmp rd=3, imm 0x05 -> result_we=0, RF[3] stays 0x05, Z=1, C=1.
- Flags C=1; and rd=3, imm 0x0F -> RF[3]=0x05, C stays 1, Z=0. lsr on 0x01 -> 0x00, C=1, Z=1.
- Illegal oper 4'hB -> illegal_oper=1, RF and flags unchanged; then rst asserted during EXEC of add -> no write, all outputs zero, instr_ready=1 the next cycle.
- With ALU_EXEC_FWD_EN: back-to-back add rd=4,imm1 ; add rd=4,imm1 from RF[4]=0 -> second result 0x02, accepts 2 cycles apart.
